// File: rtl/pcie_ss_test_seq_pkg.sv
// Shared types and width helpers for the PCIe subsystem unit-test sequencer.
package pcie_ss_test_seq_pkg;

  // Status index fields are stored at this fixed width and sliced to IDX_W at the top.
  localparam int MAX_IDX_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEL     = 3'd1,
    S_SETUP   = 3'd2,
    S_RUN     = 3'd3,
    S_GAP     = 3'd4,
    S_QUIESCE = 3'd5,
    S_DONE    = 3'd6
  } t_seq_state;

  typedef struct packed {
    logic                 pass;
    logic                 fail;
    logic                 timeout;
    logic [MAX_IDX_W-1:0] fail_idx;
    logic [MAX_IDX_W-1:0] num_run;
  } t_seq_status;

  function automatic int idx_w(input int num_tests);
    return (num_tests < 1) ? 1 : $clog2(num_tests + 1);
  endfunction

  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pcie_ss_test_seq_timer.sv
// Loadable up/down counter that saturates at both ends; shared by all timed phases.
module pcie_ss_test_seq_timer
  import pcie_ss_test_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  logic [W-1:0] value_r;

  // counter register: load beats clear beats count
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= '0;
    end else if (load) begin
      value_r <= load_val;
    end else if (clr) begin
      value_r <= '0;
    end else if (inc && (value_r != {W{1'b1}})) begin
      value_r <= value_r + W'(1);
    end else if (dec && (value_r != {W{1'b0}})) begin
      value_r <= value_r - W'(1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/pcie_ss_test_sequencer.sv
// Runs a bank of unit-test channels one at a time: reset, enable, wait done/fail,
// settle gap and quiesce reset, with timeout, skip mask and sticky status.
module pcie_ss_test_sequencer
  import pcie_ss_test_seq_pkg::*;
#(
  parameter int NUM_TESTS      = 25,
  parameter int RST_CYCLES     = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int IDX_W          = idx_w(NUM_TESTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_TESTS-1:0] test_mask,
  input  logic [NUM_TESTS-1:0] test_done,
  input  logic [NUM_TESTS-1:0] test_fail,
  output logic [NUM_TESTS-1:0] test_en,
  output logic                 test_rst,
  output logic [IDX_W-1:0]     cur_test,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [IDX_W-1:0]     fail_idx,
  output logic [IDX_W-1:0]     num_run
);

  localparam int             CNT_W   = cnt_w(RST_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  t_seq_state           state_r, next_state_s;
  logic [IDX_W-1:0]     idx_r, next_idx_s;
  t_seq_status          status_r, next_status_s;
  logic [NUM_TESTS-1:0] test_en_r;
  logic                 test_rst_r, busy_r;
  logic [IDX_W-1:0]     cur_test_r;
  logic [NUM_TESTS-1:0] sel_vec_s;
  logic                 sel_mask_s, sel_done_s, sel_fail_s;
  logic                 tmr_load_s, tmr_clr_s, tmr_inc_s, tmr_dec_s;
  logic [CNT_W-1:0]     tmr_load_val_s, tmr_value_s;

  function automatic logic [NUM_TESTS-1:0] idx_onehot(input logic [IDX_W-1:0] i);
    logic [NUM_TESTS-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_TESTS; k++) v[k] = (i == IDX_W'(k));
    return v;
  endfunction

  pcie_ss_test_seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_load_val_s),
    .clr      (tmr_clr_s),
    .inc      (tmr_inc_s),
    .dec      (tmr_dec_s),
    .value    (tmr_value_s)
  );

  // only the current channel's mask/done/fail bits are ever looked at
  always_comb begin
    sel_vec_s  = idx_onehot(idx_r);
    sel_mask_s = |(test_mask & sel_vec_s);
    sel_done_s = |(test_done & sel_vec_s);
    sel_fail_s = |(test_fail & sel_vec_s);
  end

  // next-state, index, status and timer control
  always_comb begin
    next_state_s   = state_r;
    next_idx_s     = idx_r;
    next_status_s  = status_r;
    tmr_load_s     = 1'b0;
    tmr_load_val_s = '0;
    tmr_clr_s      = 1'b0;
    tmr_inc_s      = 1'b0;
    tmr_dec_s      = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          next_status_s = '0;
          next_idx_s    = '0;
          next_state_s  = S_SEL;
        end else begin
          next_state_s  = state_r;
        end
      end
      S_SEL: begin
        if (idx_r == IDX_W'(NUM_TESTS)) begin
          next_status_s.pass = 1'b1;
          next_state_s       = S_DONE;
        end else if (!sel_mask_s) begin
          next_idx_s = idx_r + IDX_W'(1);
        end else begin
          tmr_load_s     = 1'b1;
          tmr_load_val_s = RST_LD;
          next_state_s   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tmr_value_s <= ONE) begin
          tmr_clr_s    = 1'b1;
          next_state_s = S_RUN;
        end else begin
          tmr_dec_s    = 1'b1;
        end
      end
      S_RUN: begin
        // fail wins over a same-cycle done; done wins over a same-cycle timeout
        if (sel_fail_s) begin
          next_status_s.fail     = 1'b1;
          next_status_s.fail_idx = MAX_IDX_W'(idx_r);
          next_state_s           = S_DONE;
        end else if (sel_done_s) begin
          next_status_s.num_run = status_r.num_run + MAX_IDX_W'(1);
          tmr_load_s            = 1'b1;
          tmr_load_val_s        = GAP_LD;
          next_state_s          = S_GAP;
        end else if ((TIMEOUT_CYCLES != 0) && (tmr_value_s == TO_LAST)) begin
          next_status_s.fail     = 1'b1;
          next_status_s.timeout  = 1'b1;
          next_status_s.fail_idx = MAX_IDX_W'(idx_r);
          next_state_s           = S_DONE;
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_value_s <= ONE) begin
          tmr_load_s     = 1'b1;
          tmr_load_val_s = GAP_LD;
          next_state_s   = S_QUIESCE;
        end else begin
          tmr_dec_s      = 1'b1;
        end
      end
      S_QUIESCE: begin
        if (tmr_value_s <= ONE) begin
          next_idx_s   = idx_r + IDX_W'(1);
          next_state_s = S_SEL;
        end else begin
          tmr_dec_s    = 1'b1;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // state, status and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      idx_r      <= '0;
      status_r   <= '0;
      test_en_r  <= '0;
      test_rst_r <= 1'b1;
      busy_r     <= 1'b0;
      cur_test_r <= '0;
    end else begin
      state_r    <= next_state_s;
      idx_r      <= next_idx_s;
      status_r   <= next_status_s;
      test_en_r  <= (next_state_s inside {S_SETUP, S_RUN, S_GAP}) ? idx_onehot(next_idx_s) : '0;
      test_rst_r <= !(next_state_s inside {S_RUN, S_GAP});
      busy_r     <= !(next_state_s inside {S_IDLE, S_DONE});
      cur_test_r <= (next_state_s == S_SETUP) ? next_idx_s : cur_test_r;
    end
  end

  assign test_en  = test_en_r;
  assign test_rst = test_rst_r;
  assign busy     = busy_r;
  assign cur_test = cur_test_r;
  assign pass     = status_r.pass;
  assign fail     = status_r.fail;
  assign timeout  = status_r.timeout;
  assign fail_idx = status_r.fail_idx[IDX_W-1:0];
  assign num_run  = status_r.num_run[IDX_W-1:0];

endmodule

// File: tb/tb_pcie_ss_test_sequencer.sv
// Randomised self-checking bench for pcie_ss_test_sequencer with emulated test channels.
module tb_pcie_ss_test_sequencer;

  localparam int NT    = 4;
  localparam int RSTC  = 4;
  localparam int GAPC  = 8;
  localparam int TOC   = 100;
  localparam int IW    = 3;
  localparam int LIMIT = 3000;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [NT-1:0] test_mask, test_done, test_fail, test_en;
  logic          test_rst, busy, pass, fail, timeout;
  logic [IW-1:0] cur_test, fail_idx, num_run;

  int done_dly[NT];
  int fail_dly[NT];
  int run_cnt[NT];
  int n_checks = 0;
  int n_pass   = 0;
  int en_log[$];
  int multi_hot = 0;
  logic [NT-1:0] prev_en = '0;

  always #5 clk = ~clk;

  pcie_ss_test_sequencer #(
    .NUM_TESTS(NT), .RST_CYCLES(RSTC), .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .test_mask(test_mask),
    .test_done(test_done), .test_fail(test_fail), .test_en(test_en),
    .test_rst(test_rst), .cur_test(cur_test), .busy(busy), .pass(pass),
    .fail(fail), .timeout(timeout), .fail_idx(fail_idx), .num_run(num_run)
  );

  // each emulated channel counts its enabled, out-of-reset cycles
  always @(posedge clk) begin
    for (int i = 0; i < NT; i++) begin
      if (test_rst || !test_en[i]) run_cnt[i] <= 0;
      else                         run_cnt[i] <= run_cnt[i] + 1;
    end
  end

  // done/fail levels rise a programmed number of run cycles after release
  always_comb begin
    test_done = '0;
    test_fail = '0;
    for (int i = 0; i < NT; i++) begin
      test_done[i] = test_en[i] && !test_rst && (done_dly[i] >= 0) && (run_cnt[i] >= done_dly[i]);
      test_fail[i] = test_en[i] && !test_rst && (fail_dly[i] >= 0) && (run_cnt[i] >= fail_dly[i]);
    end
  end

  function automatic int oh_index(input logic [NT-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < NT; k++) if (v[k]) r = k;
    return r;
  endfunction

  // record the order of enabled channels and any multi-hot enable
  always @(negedge clk) begin
    if ((test_en != prev_en) && (test_en != '0)) en_log.push_back(oh_index(test_en));
    if ($countones(test_en) > 1) multi_hot <= multi_hot + 1;
    prev_en <= test_en;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_en"},      32'(test_en),  32'd0);
    check_val({tag, "_rst"},     32'(test_rst), 32'd1);
    check_val({tag, "_cur"},     32'(cur_test), 32'd0);
    check_val({tag, "_busy"},    32'(busy),     32'd0);
    check_val({tag, "_pass"},    32'(pass),     32'd0);
    check_val({tag, "_fail"},    32'(fail),     32'd0);
    check_val({tag, "_timeout"}, 32'(timeout),  32'd0);
    check_val({tag, "_fidx"},    32'(fail_idx), 32'd0);
    check_val({tag, "_nrun"},    32'(num_run),  32'd0);
  endtask

  // Reference: walk the selected tests in order and decide each outcome from its
  // programmed done/fail delays, accumulating the expected sequence length.
  task automatic run_seq(input string name, input logic [NT-1:0] mask, input int poke);
    int exp_pass, exp_fail, exp_to, exp_fidx, exp_nrun, exp_dur;
    int exp_order[$];
    int stopped, d, f, c, log_base, mh_base, got_k;
    exp_pass = 0; exp_fail = 0; exp_to = 0; exp_fidx = 0; exp_nrun = 0; exp_dur = 0; stopped = 0;
    for (int i = 0; i < NT; i++) begin
      if (stopped == 0) begin
        if (!mask[i]) begin
          exp_dur += 1;
        end else begin
          exp_order.push_back(i);
          exp_dur += 1 + RSTC;
          d = done_dly[i];
          f = fail_dly[i];
          if ((f >= 0) && (f < TOC) && ((d < 0) || (f <= d))) begin
            exp_dur += f + 1; exp_fail = 1; exp_fidx = i; stopped = 1;
          end else if ((d >= 0) && (d < TOC)) begin
            exp_dur += d + 1 + 2 * GAPC; exp_nrun++;
          end else begin
            exp_dur += TOC; exp_fail = 1; exp_to = 1; exp_fidx = i; stopped = 1;
          end
        end
      end
    end
    if (stopped == 0) begin
      exp_pass = 1;
      exp_dur += 1;
    end

    log_base  = en_log.size();
    mh_base   = multi_hot;
    test_mask = mask;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c = 0;
    while (busy && (c < LIMIT)) begin
      @(negedge clk);
      c++;
      start = (poke > 0) && (c == poke);
    end
    start = 1'b0;

    check_val({name, "_cycles"},  32'(c),        32'(exp_dur));
    check_val({name, "_pass"},    32'(pass),     32'(exp_pass));
    check_val({name, "_fail"},    32'(fail),     32'(exp_fail));
    check_val({name, "_timeout"}, 32'(timeout),  32'(exp_to));
    check_val({name, "_fidx"},    32'(fail_idx), 32'(exp_fidx));
    check_val({name, "_nrun"},    32'(num_run),  32'(exp_nrun));
    check_val({name, "_en_off"},  32'(test_en),  32'd0);
    check_val({name, "_rst_on"},  32'(test_rst), 32'd1);
    check_val({name, "_multihot"}, 32'(multi_hot - mh_base), 32'd0);
    check_val({name, "_n_en"},    32'(en_log.size() - log_base), 32'(exp_order.size()));
    for (int k = 0; k < exp_order.size(); k++) begin
      got_k = (log_base + k < en_log.size()) ? en_log[log_base + k] : -1;
      check_val({name, "_en_order"}, 32'(got_k), 32'(exp_order[k]));
    end
    if (exp_order.size() > 0) check_val({name, "_cur"}, 32'(cur_test), 32'(exp_order[exp_order.size() - 1]));
  endtask

  task automatic set_all(input int d, input int f);
    for (int i = 0; i < NT; i++) begin
      done_dly[i] = d;
      fail_dly[i] = f;
    end
  endtask

  initial begin
    int found, sel;
    rst = 1'b1; start = 1'b0; test_mask = '0;
    set_all(-1, -1);
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    set_all(10, -1);
    run_seq("all_pass", 4'b1111, 0);
    run_seq("mask_0101", 4'b0101, 0);
    run_seq("mask_none", 4'b0000, 0);

    set_all(10, -1);
    done_dly[2] = -1; fail_dly[2] = 5;
    run_seq("fail_t2", 4'b1111, 0);

    set_all(-1, -1);
    run_seq("timeout_t0", 4'b1111, 0);

    set_all(10, -1);
    done_dly[0] = 99; done_dly[1] = 100;
    run_seq("done_at_limit", 4'b0011, 0);

    set_all(10, -1);
    done_dly[3] = 7; fail_dly[3] = 7;
    run_seq("done_fail_t3", 4'b1111, 3);

    // abort during the settle gap of test 1, then rerun from scratch
    set_all(10, -1);
    test_mask = 4'b1111;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 0;
    for (int c = 0; (c < LIMIT) && (found == 0); c++) begin
      @(negedge clk);
      if ((test_en == 4'b0010) && test_done[1] && !test_rst) found = 1;
    end
    check_val("gap_reached", 32'(found), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("mid_rst");
    rst = 1'b0;
    run_seq("after_rst", 4'b1111, 0);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NT; i++) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 5) begin
          done_dly[i] = int'($urandom_range(0, 20)); fail_dly[i] = -1;
        end else if (sel < 8) begin
          done_dly[i] = int'($urandom_range(0, 20)); fail_dly[i] = int'($urandom_range(0, 20));
        end else if (sel == 8) begin
          done_dly[i] = -1; fail_dly[i] = -1;
        end else begin
          done_dly[i] = int'($urandom_range(97, 102)); fail_dly[i] = -1;
        end
      end
      run_seq($sformatf("rand%0d", r), 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
